// File: rtl/xg_ram.sv
// 1024x16 true dual-port RAM with registered reads, for the XG memory manager line/attribute buffers.
// Latency 1 on both ports; no backpressure, so each port accepts a new operation every cycle.
// Define XG_RAM_BYPASS_EN so a read returns the other port's same-cycle write to the same address.
`timescale 1ns/1ps
module xg_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_a,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;

    assign rd_a = mem[address_a];
    assign rd_b = mem[address_b];

    // Port A's write is issued last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (rst_n) begin
            if (wren_b) mem[address_b] <= data_b;
            if (wren_a) mem[address_a] <= data_a;
        end
    end

`ifdef XG_RAM_BYPASS_EN
    logic same_addr;
    assign same_addr = (address_a == address_b);

    always_comb begin
        nxt_a = rd_a;
        nxt_b = rd_b;
        if (wren_a)
            nxt_a = data_a;
        else if (wren_b && same_addr)
            nxt_a = data_b;
        if (wren_a && same_addr)
            nxt_b = data_a;
        else if (wren_b)
            nxt_b = data_b;
    end
`else
    always_comb begin
        nxt_a = wren_a ? data_a : rd_a;
        nxt_b = wren_b ? data_b : rd_b;
    end
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= nxt_a;
            q_b <= nxt_b;
        end
    end

endmodule

// File: tb/tb_xg_ram.sv
// Bench for xg_ram: directed cases then random traffic against an array-based reference.
`timescale 1ns/1ps
module tb_xg_ram;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b;
    logic          wren_a, wren_b;
    logic [DW-1:0] q_a, q_b;

    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] exp_a, exp_b;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    xg_ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .rst_n(rst_n),
        .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b),
        .wren_a(wren_a), .wren_b(wren_b),
        .q_a(q_a), .q_b(q_b)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operation per port, predict from the reference, clock it, then check both outputs.
    task automatic cycle(input string tag,
                         input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        wren_a = wa; address_a = aa; data_a = da;
        wren_b = wb; address_b = ab; data_b = db;
        if (rst_n) begin
            exp_a = wa ? da : ref_mem[aa];
            exp_b = wb ? db : ref_mem[ab];
`ifdef XG_RAM_BYPASS_EN
            if (aa == ab) begin
                if (wa)      exp_b = da;
                else if (wb) exp_a = db;
            end
`endif
            if (wb) ref_mem[ab] = db;
            if (wa) ref_mem[aa] = da;
        end else begin
            exp_a = '0;
            exp_b = '0;
        end
        @(posedge clock);
        #1;
        check({tag, ".q_a"}, q_a, exp_a);
        check({tag, ".q_b"}, q_b, exp_b);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        rst_n = 1'b0;
        wren_a = 1'b0; wren_b = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        #1;
        check("reset.q_a", q_a, 16'h0000);
        check("reset.q_b", q_b, 16'h0000);
        cycle("rst_hold", 1'b1, 10'h010, 16'hFFFF, 1'b0, 10'h000, 16'h0000);
        rst_n = 1'b1;

        cycle("init_rd",  1'b0, 10'h000, 16'h0000, 1'b0, 10'h000, 16'h0000);
        check("init_rd.abs", q_b, 16'h0000);
        cycle("a_wr",     1'b1, 10'h3C5, 16'h1234, 1'b0, 10'h000, 16'h0000);
        cycle("b_rd",     1'b0, 10'h000, 16'h0000, 1'b0, 10'h3C5, 16'h0000);
        check("b_rd.abs", q_b, 16'h1234);
        cycle("b_wr",     1'b0, 10'h000, 16'h0000, 1'b1, 10'h001, 16'hBEEF);
        cycle("a_rd",     1'b0, 10'h001, 16'h0000, 1'b0, 10'h000, 16'h0000);
        check("a_rd.abs", q_a, 16'hBEEF);
        cycle("wthru",    1'b1, 10'h200, 16'hA5A5, 1'b0, 10'h000, 16'h0000);
        check("wthru.abs", q_a, 16'hA5A5);
        cycle("wthru_rd", 1'b0, 10'h200, 16'h0000, 1'b0, 10'h000, 16'h0000);
        check("wthru_rd.abs", q_a, 16'hA5A5);

        cycle("rdw_pre",  1'b1, 10'h100, 16'h1111, 1'b0, 10'h000, 16'h0000);
        cycle("rdw",      1'b1, 10'h100, 16'h2222, 1'b0, 10'h100, 16'h0000);
`ifdef XG_RAM_BYPASS_EN
        check("rdw.abs", q_b, 16'h2222);
`else
        check("rdw.abs", q_b, 16'h1111);
`endif
        cycle("rdw_post", 1'b0, 10'h000, 16'h0000, 1'b0, 10'h100, 16'h0000);
        check("rdw_post.abs", q_b, 16'h2222);

        cycle("coll",     1'b1, 10'h3FF, 16'h0AAA, 1'b1, 10'h3FF, 16'h0BBB);
`ifdef XG_RAM_BYPASS_EN
        check("coll.abs", q_b, 16'h0AAA);
`else
        check("coll.abs", q_b, 16'h0BBB);
`endif
        cycle("coll_rd",  1'b0, 10'h3FF, 16'h0000, 1'b0, 10'h3FF, 16'h0000);
        check("coll_rd.abs_a", q_a, 16'h0AAA);
        check("coll_rd.abs_b", q_b, 16'h0AAA);

        cycle("pre_rst",  1'b1, 10'h010, 16'h5555, 1'b0, 10'h3FF, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.q_a", q_a, 16'h0000);
        check("async_rst.q_b", q_b, 16'h0000);
        for (int i = 0; i < 3; i++)
            cycle("rst_wr", 1'b1, 10'h010, 16'hFFFF, 1'b0, 10'h010, 16'h0000);
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, 10'h010, 16'h0000, 1'b0, 10'h010, 16'h0000);
        check("post_rst.abs", q_a, 16'h5555);

        // Narrow address window so collisions and cross-port hits are frequent.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cycle("rand", 1'($urandom), ra, DW'($urandom), 1'($urandom), rb, DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xg_ram.md
Name: xg_ram

Overview:
- 1024 x 16 true dual-port synchronous RAM used by the XG graphics memory manager.
- Holds two pattern line buffers and two tile-attribute buffers.
- Port A serves the refill state machine: it reads attribute indices and writes fetched pattern/attribute words.
- Port B serves the pixel pipeline, which only reads.
- Both ports run on one clock and have a one-cycle registered read latency.

Parameters:
- ADDR_W, 10, address width per port; depth = 2**ADDR_W words.
- DATA_W, 16, word width per port.

Ports:
- clock  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address_a  input  ADDR_W  port A word address.
- address_b  input  ADDR_W  port B word address.
- data_a  input  DATA_W  port A write data.
- data_b  input  DATA_W  port B write data.
- wren_a  input  1  port A write enable.
- wren_b  input  1  port B write enable.
- q_a  output  DATA_W  port A registered read data.
- q_b  output  DATA_W  port B registered read data.

Behaviour:
- Storage and initial state:
  - Storage is an array mem[0..2**ADDR_W-1] of DATA_W bits.
  - Initial content is all zeros (initialised at elaboration); reset never clears the array.
- Reset:
  - rst_n low asynchronously forces q_a = 0 and q_b = 0.
  - Both outputs hold 0 while rst_n is low.
  - Writes are suppressed while rst_n is low.
  - Deassertion is synchronised by the user; the first edge with rst_n high operates normally.
- Read timing: at a rising edge, each port registers mem[address_x]. q_x shows that value after the edge and holds it until the next edge (latency 1).
- Write: at a rising edge with wren_x = 1, mem[address_x] <= data_x.
- Same-port read-during-write: new-data (write-through) behaviour. q_x after the edge equals data_x.
- Cross-port, both writing the same address in one cycle: port A wins, so mem gets data_a. Port B's q_b still shows data_b (its own write-through).
- Cross-port, one port writes while the other reads the same address in one cycle: the reader gets the OLD content (pre-write value) unless XG_RAM_BYPASS_EN is defined.
- Different addresses: the ports are fully independent with no interaction.
- Address wrap: addresses are exactly ADDR_W bits, so no out-of-range access exists.
- X/unknown addresses or data: no behaviour guaranteed. The implementation must not corrupt other addresses when address and write enable are valid.
- No handshake, no busy state, no state machine; every cycle accepts a new operation on each port.

Optional Feature:
- XG_RAM_BYPASS_EN is defined: cross-port forwarding.
  - If port A writes address X while port B reads X in the same cycle, q_b after the edge equals data_a.
  - Symmetrically, if port B writes while port A reads the same address, q_a after the edge equals data_b.
  - If both ports write the same address, each q shows port A's data, consistent with port A winning.
- XG_RAM_BYPASS_EN is not defined: the reader gets the old data as described above.
- The feature is built as a comparator plus mux in front of the output registers; the array itself is unchanged.

Test Plan:
- Reset: hold rst_n=0 mid-run after reads → q_a=q_b=0 immediately (asynchronous). Release, read address 0x000 on both ports → 0x0000 (initial contents).
- Basic write/read:
  - Port A writes 0x1234 at 0x3C5; next cycle port B reads 0x3C5 → q_b=0x1234 one edge later.
  - Port B writes 0xBEEF at 0x001; port A reads it → q_a=0xBEEF.
- Same-port write-through: wren_a=1, address_a=0x200, data_a=0xA5A5 → q_a=0xA5A5 after that edge. Then read 0x200 with wren_a=0 → still 0xA5A5.
- Cross-port read-during-write: mem[0x100]=0x1111; port A writes 0x2222 to 0x100 while port B reads 0x100:
  - without XG_RAM_BYPASS_EN → q_b=0x1111 that cycle and 0x2222 on the next read.
  - with XG_RAM_BYPASS_EN → q_b=0x2222 immediately.
- Write collision: both ports write 0x3FF in the same cycle (A=0x0AAA, B=0x0BBB) → subsequent read of 0x3FF on either port returns 0x0AAA.
- Reset mid-operation:
  - Write 0x5555 at 0x010, then assert rst_n=0 for 3 cycles with wren_a=1 and data_a=0xFFFF at 0x010 → q_a/q_b stay 0.
  - After release, read 0x010 → 0x5555 (write suppressed, contents kept).
